fmc516_adc_stream_packer: RTL and testbench
===========================================

# fmc516_adc_stream_packer

Downstream consumer of the FMC516 ADC front-end's continuous sample outputs (four 16-bit channels plus a data-valid strobe, already in the system clock domain). It buffers each sample set in an internal FIFO and emits fixed-size packets on a pipelined Wishbone streaming source for the acquisition/DMA fabric. It flags sample loss and bus errors with sticky status bits and counts completed packets.

## Interface
- g_packet_size, 32: words per packet; range 1..g_fifo_depth/2.
- g_fifo_depth, 256: FIFO depth in 64-bit words; power of 2, ≥ 2·g_packet_size.
- g_cnt_width, 9: width of fifo_count_o; equals log2(g_fifo_depth)+1.

Ports:
- sys_clk_i  in  1  system clock; all logic on rising edge.
- sys_rst_n_i  in  1  asynchronous active-low reset.
- enable_i  in  1  accept samples and start new packets when 1.
- adc_data_ch0_i..adc_data_ch3_i  in  16 each  ADC channel samples.
- adc_data_valid_i  in  1  sample set valid this cycle.
- clear_i  in  1  single-cycle pulse; clears overflow_o and stream_err_o.
- wbs_adr_o  out  2  always 2'b00 (data word).
- wbs_dat_o  out  64  {ch3,ch2,ch1,ch0}.
- wbs_cyc_o, wbs_stb_o, wbs_we_o  out  1 each  streaming bus controls; we equals cyc.
- wbs_sel_o  out  8  8'hFF while stb, else 0.
- wbs_ack_i, wbs_stall_i, wbs_err_i  in  1 each  sink responses.
- fifo_count_o  out  g_cnt_width  FIFO occupancy.
- pkt_count_o  out  16  completed packets, wraps modulo 2^16.
- overflow_o  out  1  sticky: sample dropped on full FIFO.
- stream_err_o  out  1  sticky: wbs_err_i seen.

## Operation
- Write: adc_data_valid_i=1 and enable_i=1 and FIFO not full → word pushed. If FIFO full, the word is discarded and overflow_o is set. Same-cycle push and pop on a full FIFO: push accepted.
- The FIFO is first-word-fall-through; its head drives wbs_dat_o.
- FSM states:
  - IDLE: cyc=stb=0. Go to SEND when enable_i=1 and fifo_count_o ≥ g_packet_size.
  - SEND: cyc=stb=1. A word is accepted when stb=1 and wbs_stall_i=0; accepted words pop the FIFO and increment sent. On acceptance of word g_packet_size → WAIT_ACK, stb=0 from the next cycle.
  - WAIT_ACK: cyc=1, stb=0. When outstanding reaches 0 → IDLE, cyc=0, pkt_count_o+1.
- outstanding counter: +1 on acceptance, −1 on wbs_ack_i or wbs_err_i; both in the same cycle → unchanged. Ack/err outside cyc is ignored.
- wbs_err_i sets stream_err_o. The packet still completes; words are not retried.
- enable_i falling mid-packet: the current packet completes; no new packet starts.
- clear_i in the same cycle as a new overflow or error: the set wins and the flag stays 1.
- No ack timeout. A sink that never acks holds WAIT_ACK indefinitely; only reset recovers.

## Timing
- Reset values: cyc, stb, we, sel, adr, dat = 0; fifo_count_o=0; pkt_count_o=0; overflow_o=0; stream_err_o=0; FSM=IDLE; FIFO empty. Reset asserted mid-packet drops the packet and the buffered data immediately.
- Push: a sample valid at edge k is reflected in fifo_count_o after edge k.
- Start latency: if fifo_count_o reaches g_packet_size after edge k, cyc and stb are high after edge k+1.
- Throughput: one word per cycle while stall=0; a packet occupies exactly g_packet_size stb cycles plus any stall cycles.
- Back-to-back packets: cyc stays low for at least one cycle between packets.
- Flags update one edge after the triggering event.

## Test plan
- Reset, then 32 consecutive valid samples with ch0=n, ch1=n+1, ch2=n+2, ch3=n+3, stall=0, ack one cycle after each stb → one packet of 32 words, dat in order, pkt_count_o=1, fifo_count_o=0, cyc low afterwards.
- Same stimulus with wbs_stall_i asserted on every other cycle → 32 words still accepted with no duplicates or losses; stb held during stall.
- Enable on, sink held in permanent stall, 300 valid samples → fifo_count_o=256, overflow_o=1. Then clear_i → overflow_o=0. Release stall → exactly 8 packets drain.
- wbs_err_i in place of the ack for word 5 → stream_err_o=1, packet completes, pkt_count_o increments.
- enable_i dropped mid-packet → that packet completes; no further cyc while fifo_count_o ≥ 32.
- sys_rst_n_i asserted mid-packet → cyc=stb=0 and all counters 0 on the same cycle; operation after release matches the first scenario.

Source files
------------

// File: rtl/fmc516_adc_stream_packer.sv
// fmc516_adc_stream_packer
// Buffers FMC516 ADC sample sets (four 16-bit channels) in a first-word-fall-through
// FIFO. Drains them as fixed-size packets on a pipelined Wishbone streaming source.
// Sticky flags report dropped samples and bus errors. A counter tracks finished packets.

module fmc516_adc_stream_packer #(
  parameter int g_packet_size = 32,
  parameter int g_fifo_depth  = 256,
  parameter int g_cnt_width   = 9
) (
  input  logic                   sys_clk_i,
  input  logic                   sys_rst_n_i,
  input  logic                   enable_i,
  input  logic [15:0]            adc_data_ch0_i,
  input  logic [15:0]            adc_data_ch1_i,
  input  logic [15:0]            adc_data_ch2_i,
  input  logic [15:0]            adc_data_ch3_i,
  input  logic                   adc_data_valid_i,
  input  logic                   clear_i,
  output logic [1:0]             wbs_adr_o,
  output logic [63:0]            wbs_dat_o,
  output logic                   wbs_cyc_o,
  output logic                   wbs_stb_o,
  output logic                   wbs_we_o,
  output logic [7:0]             wbs_sel_o,
  input  logic                   wbs_ack_i,
  input  logic                   wbs_stall_i,
  input  logic                   wbs_err_i,
  output logic [g_cnt_width-1:0] fifo_count_o,
  output logic [15:0]            pkt_count_o,
  output logic                   overflow_o,
  output logic                   stream_err_o
);

  localparam int LP_AW = $clog2(g_fifo_depth);
  localparam int LP_OW = $clog2(g_packet_size + 1);

  localparam logic [g_cnt_width-1:0] LP_DEPTH    = g_cnt_width'(g_fifo_depth);
  localparam logic [g_cnt_width-1:0] LP_PKT_WORDS = g_cnt_width'(g_packet_size);
  localparam logic [LP_OW-1:0]       LP_PKT_LAST  = LP_OW'(g_packet_size - 1);
  localparam logic [LP_OW-1:0]       LP_OW_ONE    = LP_OW'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_ACK
  } t_state;

  t_state                 r_state;
  logic                   r_cyc;
  logic                   r_stb;
  logic [LP_OW-1:0]       r_sent;
  logic [LP_OW-1:0]       r_outstanding;
  logic [15:0]            r_pkt_count;
  logic                   r_overflow;
  logic                   r_stream_err;

  logic [63:0]            r_mem [g_fifo_depth];
  logic [LP_AW-1:0]       r_wr_ptr;
  logic [LP_AW-1:0]       r_rd_ptr;
  logic [g_cnt_width-1:0] r_fifo_count;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_sample;
  logic                   w_accept;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_drop;
  logic                   w_ack;
  logic                   w_err;
  logic                   w_resp;
  logic [LP_OW-1:0]       w_outstanding_next;

  assign w_full   = (r_fifo_count == LP_DEPTH);
  assign w_empty  = (r_fifo_count == '0);
  assign w_sample = adc_data_valid_i & enable_i;
  assign w_accept = r_stb & ~wbs_stall_i;
  assign w_pop    = w_accept;
  // A pop in the same cycle frees a slot, so a full FIFO still takes the new word
  assign w_push   = w_sample & (~w_full | w_pop);
  assign w_drop   = w_sample & ~w_push;
  assign w_ack    = r_cyc & wbs_ack_i;
  assign w_err    = r_cyc & wbs_err_i;
  assign w_resp   = w_ack | w_err;

  // Count words accepted by the sink but not yet acknowledged
  always_comb begin
    w_outstanding_next = r_outstanding;
    if (w_accept && !w_resp) begin
      w_outstanding_next = r_outstanding + LP_OW_ONE;
    end else if (!w_accept && w_resp) begin
      w_outstanding_next = r_outstanding - LP_OW_ONE;
    end
  end

  // FIFO storage: no reset needed, validity is tracked by the pointers and count
  always_ff @(posedge sys_clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {adc_data_ch3_i, adc_data_ch2_i, adc_data_ch1_i, adc_data_ch0_i};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + 1'b1;
        2'b01:   r_fifo_count <= r_fifo_count - 1'b1;
        default: r_fifo_count <= r_fifo_count;
      endcase
    end
  end

  // Track responses outstanding so the cycle closes only after every word is answered
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      r_outstanding <= '0;
    end else begin
      r_outstanding <= w_outstanding_next;
    end
  end

  // Packet FSM with registered bus controls and the completed-packet counter
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      r_state     <= ST_IDLE;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_sent      <= '0;
      r_pkt_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable_i && (r_fifo_count >= LP_PKT_WORDS)) begin
            r_state <= ST_SEND;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_sent  <= '0;
          end
        end
        ST_SEND: begin
          if (w_accept) begin
            if (r_sent == LP_PKT_LAST) begin
              r_state <= ST_WAIT_ACK;
              r_stb   <= 1'b0;
            end else begin
              r_sent <= r_sent + LP_OW_ONE;
            end
          end
        end
        ST_WAIT_ACK: begin
          if (w_outstanding_next == '0) begin
            r_state     <= ST_IDLE;
            r_cyc       <= 1'b0;
            r_pkt_count <= r_pkt_count + 16'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cyc   <= 1'b0;
          r_stb   <= 1'b0;
        end
      endcase
    end
  end

  // Sticky status flags: a new event in the same cycle as clear keeps the flag set
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      r_overflow   <= 1'b0;
      r_stream_err <= 1'b0;
    end else begin
      if (w_drop)       r_overflow <= 1'b1;
      else if (clear_i) r_overflow <= 1'b0;
      if (w_err)        r_stream_err <= 1'b1;
      else if (clear_i) r_stream_err <= 1'b0;
    end
  end

  // Data is the FIFO head; forced to zero when empty so reset shows a clean bus
  assign wbs_dat_o    = w_empty ? 64'd0 : r_mem[r_rd_ptr];
  assign wbs_adr_o    = 2'b00;
  assign wbs_cyc_o    = r_cyc;
  assign wbs_stb_o    = r_stb;
  assign wbs_we_o     = r_cyc;
  assign wbs_sel_o    = r_stb ? 8'hFF : 8'h00;
  assign fifo_count_o = r_fifo_count;
  assign pkt_count_o  = r_pkt_count;
  assign overflow_o   = r_overflow;
  assign stream_err_o = r_stream_err;

endmodule

// File: tb/tb_fmc516_adc_stream_packer.sv
// Testbench for fmc516_adc_stream_packer
// Scoreboard of expected bus words plus scenario checks of counters and flags

module tb_fmc516_adc_stream_packer;

  localparam int PKT   = 32;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rstN;
  logic        enable;
  logic [15:0] ch0, ch1, ch2, ch3;
  logic        valid;
  logic        clear;
  logic [1:0]  adr;
  logic [63:0] dat;
  logic        cyc, stb, we;
  logic [7:0]  sel;
  logic        ack   = 1'b0;
  logic        stall = 1'b0;
  logic        err   = 1'b0;
  logic [8:0]  fifoCount;
  logic [15:0] pktCount;
  logic        overflow;
  logic        streamErr;

  int          numCompared   = 0;
  int          numMismatched = 0;
  logic [63:0] expQ[$];
  int          stallMode     = 0;
  int          errWordIdx    = -1;
  logic        acceptSeen    = 1'b0;
  int          acceptWordIdx = 0;
  int          acceptIdx     = 0;
  int          cycHighCount  = 0;

  fmc516_adc_stream_packer #(
    .g_packet_size(PKT),
    .g_fifo_depth (DEPTH),
    .g_cnt_width  (9)
  ) dut (
    .sys_clk_i       (clk),
    .sys_rst_n_i     (rstN),
    .enable_i        (enable),
    .adc_data_ch0_i  (ch0),
    .adc_data_ch1_i  (ch1),
    .adc_data_ch2_i  (ch2),
    .adc_data_ch3_i  (ch3),
    .adc_data_valid_i(valid),
    .clear_i         (clear),
    .wbs_adr_o       (adr),
    .wbs_dat_o       (dat),
    .wbs_cyc_o       (cyc),
    .wbs_stb_o       (stb),
    .wbs_we_o        (we),
    .wbs_sel_o       (sel),
    .wbs_ack_i       (ack),
    .wbs_stall_i     (stall),
    .wbs_err_i       (err),
    .fifo_count_o    (fifoCount),
    .pkt_count_o     (pktCount),
    .overflow_o      (overflow),
    .stream_err_o    (streamErr)
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one sample set (n, n+1, n+2, n+3) for one clock cycle
  task automatic applyStimulus(input logic v, input logic [15:0] n);
    valid = v;
    ch0   = n;
    ch1   = n + 16'd1;
    ch2   = n + 16'd2;
    ch3   = n + 16'd3;
    @(posedge clk);
    #1;
  endtask

  task automatic waitPkt(input int target, input int budget);
    int i;
    i = 0;
    while (pktCount != 16'(target) && i < budget) begin
      applyStimulus(1'b0, 16'd0);
      i++;
    end
    checkOutput("pkt_count", 64'(pktCount), 64'(target));
  endtask

  // One packet: 32 samples, start-latency check, then drain and completion checks
  task automatic runPacket(input logic [15:0] base, input int expPkt);
    enable = 1'b1;
    for (int n = 0; n < PKT; n++) applyStimulus(1'b1, base + 16'(n));
    checkOutput("start_count", 64'(fifoCount), 64'(PKT));
    checkOutput("start_cyc_lo", 64'(cyc), 64'd0);
    applyStimulus(1'b0, 16'd0);
    checkOutput("start_cyc_hi", 64'(cyc), 64'd1);
    checkOutput("start_stb_hi", 64'(stb), 64'd1);
    waitPkt(expPkt, 400);
    checkOutput("end_fifo_count", 64'(fifoCount), 64'd0);
    checkOutput("end_cyc", 64'(cyc), 64'd0);
    checkOutput("end_queue", 64'(expQ.size()), 64'd0);
  endtask

  // Monitor at negedge: per-cycle bus checks, scoreboard pop on accepted words, push on accepted samples
  always @(negedge clk) begin : monitor
    logic pop;
    logic expStb;
    logic [63:0] w;
    if (!rstN) begin
      expQ.delete();
      acceptIdx  = 0;
      acceptSeen = 1'b0;
    end else begin
      if (!cyc) acceptIdx = 0;
      else cycHighCount++;
      checkOutput("fifo_count", 64'(fifoCount), 64'(expQ.size()));
      expStb = cyc && (acceptIdx < PKT);
      checkOutput("stb", 64'(stb), 64'(expStb));
      checkOutput("sel", 64'(sel), expStb ? 64'hFF : 64'h00);
      checkOutput("we", 64'(we), 64'(cyc));
      checkOutput("adr", 64'(adr), 64'd0);
      pop = stb && !stall;
      acceptSeen    = pop;
      acceptWordIdx = acceptIdx;
      if (pop) begin
        checkOutput("queue_nonempty", 64'(expQ.size() != 0), 64'd1);
        if (expQ.size() != 0) begin
          w = expQ.pop_front();
          checkOutput("dat", dat, w);
        end
        acceptIdx++;
      end
      if (valid && enable && (expQ.size() < DEPTH || pop)) begin
        expQ.push_back({ch3, ch2, ch1, ch0});
      end
    end
  end

  // Sink model: answers each accepted word one cycle later, stalls per the selected mode
  always @(posedge clk) begin
    #1;
    ack = 1'b0;
    err = 1'b0;
    if (acceptSeen) begin
      if (acceptWordIdx == errWordIdx) err = 1'b1;
      else ack = 1'b1;
    end
    case (stallMode)
      1:       stall = ~stall;
      2:       stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  // Hard stop in case something hangs
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence
  initial begin
    rstN   = 1'b0;
    enable = 1'b0;
    valid  = 1'b0;
    clear  = 1'b0;
    ch0 = '0; ch1 = '0; ch2 = '0; ch3 = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cyc", 64'(cyc), 64'd0);
    checkOutput("rst_stb", 64'(stb), 64'd0);
    checkOutput("rst_we", 64'(we), 64'd0);
    checkOutput("rst_sel", 64'(sel), 64'd0);
    checkOutput("rst_adr", 64'(adr), 64'd0);
    checkOutput("rst_dat", dat, 64'd0);
    checkOutput("rst_fifo_count", 64'(fifoCount), 64'd0);
    checkOutput("rst_pkt_count", 64'(pktCount), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);
    checkOutput("rst_stream_err", 64'(streamErr), 64'd0);
    rstN = 1'b1;
    applyStimulus(1'b0, 16'd0);

    $display("[TB] basic packet");
    runPacket(16'd0, 1);

    $display("[TB] packet with alternating stall");
    stallMode = 1;
    runPacket(16'd100, 2);
    stallMode = 0;

    $display("[TB] overflow with permanent stall");
    stallMode = 2;
    enable = 1'b1;
    for (int n = 0; n < 300; n++) applyStimulus(1'b1, 16'd1000 + 16'(n));
    checkOutput("full_fifo_count", 64'(fifoCount), 64'd256);
    checkOutput("overflow_set", 64'(overflow), 64'd1);
    clear = 1'b1;
    applyStimulus(1'b1, 16'd2000);
    clear = 1'b0;
    checkOutput("overflow_set_wins", 64'(overflow), 64'd1);
    checkOutput("full_fifo_count2", 64'(fifoCount), 64'd256);
    clear = 1'b1;
    applyStimulus(1'b0, 16'd0);
    clear = 1'b0;
    checkOutput("overflow_cleared", 64'(overflow), 64'd0);
    stallMode = 0;
    waitPkt(10, 1000);
    repeat (60) applyStimulus(1'b0, 16'd0);
    checkOutput("drain_pkt_count", 64'(pktCount), 64'd10);
    checkOutput("drain_fifo_count", 64'(fifoCount), 64'd0);
    checkOutput("drain_queue", 64'(expQ.size()), 64'd0);

    $display("[TB] error response on word 5");
    errWordIdx = 4;
    runPacket(16'd3000, 11);
    errWordIdx = -1;
    checkOutput("stream_err_set", 64'(streamErr), 64'd1);
    clear = 1'b1;
    applyStimulus(1'b0, 16'd0);
    clear = 1'b0;
    checkOutput("stream_err_cleared", 64'(streamErr), 64'd0);
    checkOutput("overflow_still_clear", 64'(overflow), 64'd0);

    $display("[TB] enable dropped mid-packet");
    stallMode = 1;
    enable = 1'b1;
    for (int n = 0; n < 64; n++) applyStimulus(1'b1, 16'd4000 + 16'(n));
    checkOutput("midpkt_cyc", 64'(cyc), 64'd1);
    enable = 1'b0;
    waitPkt(12, 400);
    checkOutput("after_drop_fifo", 64'(fifoCount), 64'd32);
    cycHighCount = 0;
    repeat (50) applyStimulus(1'b0, 16'd0);
    checkOutput("no_new_cyc", 64'(cycHighCount), 64'd0);
    checkOutput("after_drop_pkt", 64'(pktCount), 64'd12);

    $display("[TB] reset mid-packet");
    enable = 1'b1;
    repeat (8) applyStimulus(1'b0, 16'd0);
    checkOutput("pre_reset_cyc", 64'(cyc), 64'd1);
    rstN = 1'b0;
    #1;
    checkOutput("mid_rst_cyc", 64'(cyc), 64'd0);
    checkOutput("mid_rst_stb", 64'(stb), 64'd0);
    checkOutput("mid_rst_fifo", 64'(fifoCount), 64'd0);
    checkOutput("mid_rst_pkt", 64'(pktCount), 64'd0);
    checkOutput("mid_rst_overflow", 64'(overflow), 64'd0);
    checkOutput("mid_rst_stream_err", 64'(streamErr), 64'd0);
    checkOutput("mid_rst_dat", dat, 64'd0);
    enable = 1'b0;
    stallMode = 0;
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    applyStimulus(1'b0, 16'd0);
    runPacket(16'd0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
